// File: rtl/bg_scroll_scheduler_pkg.sv
// Shared types and constants for the background scroll scheduler.
// No logic here, so there is no latency and no backpressure.
package bg_pkg;

    typedef enum logic [1:0] {
        SCROLL   = 2'd0,
        FADE_OUT = 2'd1,
        FADE_IN  = 2'd2
    } bg_state_t;

    localparam logic [2:0] BRIGHT_MAX    = 3'd7;
    localparam int         TILE_BITS_DEF = 5;

    typedef logic [1:0] lvl_id_t;

endpackage

// File: rtl/bg_scroll_scheduler_step_timer.sv
// Counts frame pulses modulo STEP_FRAMES; step fires on the last pulse of each group.
// step is combinational from the sof input; there is no backpressure, and clr wins over sof.
module bg_step_timer #(
    parameter int STEP_FRAMES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic sof,
    output logic step
);

    localparam int             CW   = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
    localparam logic [CW-1:0]  LAST = CW'(STEP_FRAMES - 1);

    logic [CW-1:0] cnt;

    assign step = sof && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (sof) begin
            cnt <= step ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/bg_scroll_scheduler.sv
// Scroll offsets, tile addressing and the level-change fade sequencer for the background drawer.
// Tile addresses have 1 cycle of latency; level requests are held by the requester until lvl_ack.
module bg_scroll_scheduler
    import bg_pkg::*;
#(
    parameter int TILE_BITS   = TILE_BITS_DEF,
    parameter int STEP_FRAMES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 startOfFrame,
    input  logic [10:0]          pixelX,
    input  logic [10:0]          pixelY,
    input  logic                 scroll_en,
    input  logic [1:0]           speedX,
    input  logic [1:0]           speedY,
    input  logic                 lvl_req,
    input  logic [1:0]           lvl_id,
    output logic                 lvl_ack,
    output logic [TILE_BITS-1:0] tileX,
    output logic [TILE_BITS-1:0] tileY,
    output logic [1:0]           tile_sel,
    output logic [2:0]           brightness,
    output logic                 busy
);

    bg_state_t            state;
    logic [TILE_BITS-1:0] offX;
    logic [TILE_BITS-1:0] offY;
    lvl_id_t              pending_id;
    logic                 step;
    logic                 enter;
    logic                 accept;
    logic                 fade_acc;

    // The ack cycle is excluded so a request still high in that cycle is not accepted twice.
    assign accept   = (state == SCROLL) && lvl_req && !lvl_ack;
    assign fade_acc = accept && (lvl_id != tile_sel);
    assign busy     = (state != SCROLL);

    always_comb begin
        enter = 1'b0;
        case (state)
            SCROLL:   enter = fade_acc;
            FADE_OUT: enter = step && (brightness == 3'd0);
            FADE_IN:  enter = step && (brightness == BRIGHT_MAX);
            default:  enter = 1'b0;
        endcase
    end

    // Clearing on the transition edge means a frame pulse coincident with acceptance is not counted.
    bg_step_timer #(
        .STEP_FRAMES (STEP_FRAMES)
    ) u_step_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (enter),
        .sof   (startOfFrame),
        .step  (step)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SCROLL;
            offX       <= '0;
            offY       <= '0;
            pending_id <= '0;
            tile_sel   <= '0;
            brightness <= BRIGHT_MAX;
            tileX      <= '0;
            tileY      <= '0;
            lvl_ack    <= 1'b0;
        end else begin
            lvl_ack <= accept;

            if (startOfFrame && scroll_en) begin
                offX <= offX + TILE_BITS'(speedX);
                offY <= offY + TILE_BITS'(speedY);
            end

            tileX <= pixelX[TILE_BITS-1:0] + offX;
            tileY <= pixelY[TILE_BITS-1:0] + offY;

            case (state)
                SCROLL: begin
                    if (fade_acc) begin
                        pending_id <= lvl_id;
                        state      <= FADE_OUT;
                    end
                end
                FADE_OUT: begin
                    if (step) begin
                        if (brightness != 3'd0) begin
                            brightness <= brightness - 3'd1;
                        end else begin
                            tile_sel <= pending_id;
                            state    <= FADE_IN;
                        end
                    end
                end
                FADE_IN: begin
                    if (step) begin
                        if (brightness != BRIGHT_MAX) begin
                            brightness <= brightness + 3'd1;
                        end else begin
                            state <= SCROLL;
                        end
                    end
                end
                default: state <= SCROLL;
            endcase
        end
    end

endmodule
